// File: rtl/gcd_stein.sv
// WIDTH-bit binary (Stein) GCD engine with start/finish handshake and iteration count.
// Define GCD_STEIN_CONST_TIME_EN to pad every operation to CT_CYCLES iterations.
module gcd_stein #(
  parameter int WIDTH     = 16,
  parameter int ITER_W    = 10,
  parameter int CT_CYCLES = 4*WIDTH+2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  output logic [WIDTH-1:0]  gcd,
  output logic              finish,
  output logic              busy,
  output logic [ITER_W-1:0] iters
);

  localparam int KW = $clog2(WIDTH+1);

  if (WIDTH < 2) begin : g_bad_width
    $error("gcd_stein: WIDTH must be >= 2");
  end
  if (CT_CYCLES < 4*WIDTH+1) begin : g_bad_ct
    $error("gcd_stein: CT_CYCLES must be >= 4*WIDTH+1");
  end

`ifdef GCD_STEIN_CONST_TIME_EN
  typedef enum logic [1:0] {IDLE, CALC, DONE, PAD} state_t;
`else
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
`endif

  state_t state, state_n;

  logic [WIDTH-1:0]  x, x_n;
  logic [WIDTH-1:0]  y, y_n;
  logic [KW-1:0]     k, k_n;
  logic [ITER_W-1:0] cnt, cnt_n, cnt_inc;
  logic [WIDTH-1:0]  gcd_q, gcd_n;
  logic [ITER_W-1:0] iters_q, iters_n;
  logic              fin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      x       <= '0;
      y       <= '0;
      k       <= '0;
      cnt     <= '0;
      gcd_q   <= '0;
      iters_q <= '0;
    end else begin
      state   <= state_n;
      x       <= x_n;
      y       <= y_n;
      k       <= k_n;
      cnt     <= cnt_n;
      gcd_q   <= gcd_n;
      iters_q <= iters_n;
    end
  end

  // saturating iteration counter
  assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

  always_comb begin
    state_n = state;
    x_n     = x;
    y_n     = y;
    k_n     = k;
    cnt_n   = cnt;
    gcd_n   = gcd_q;
    iters_n = iters_q;
    fin     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          x_n     = a;
          y_n     = b;
          k_n     = '0;
          cnt_n   = '0;
          state_n = CALC;
        end
      end
      CALC: begin
        cnt_n = cnt_inc;
        // rule order guarantees the subtractions never underflow
        priority case (1'b1)
          (x == '0): begin
            gcd_n = y << k;
            fin   = 1'b1;
          end
          (y == '0): begin
            gcd_n = x << k;
            fin   = 1'b1;
          end
          (!x[0] && !y[0]): begin
            x_n = x >> 1;
            y_n = y >> 1;
            k_n = k + 1'b1;
          end
          (!x[0]): x_n = x >> 1;
          (!y[0]): y_n = y >> 1;
          (x >= y): x_n = x - y;
          default: y_n = y - x;
        endcase
        if (fin) begin
`ifdef GCD_STEIN_CONST_TIME_EN
          if (cnt_inc == ITER_W'(CT_CYCLES)) begin
            state_n = DONE;
            iters_n = cnt_inc;
          end else begin
            state_n = PAD;
          end
`else
          state_n = DONE;
          iters_n = cnt_inc;
`endif
        end
      end
`ifdef GCD_STEIN_CONST_TIME_EN
      PAD: begin
        cnt_n = cnt_inc;
        if (cnt_inc == ITER_W'(CT_CYCLES)) begin
          state_n = DONE;
          iters_n = cnt_inc;
        end
      end
`endif
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign gcd    = gcd_q;
  assign iters  = iters_q;
  assign finish = (state == DONE);
  assign busy   = (state != IDLE);

endmodule

// File: tb/tb_gcd_stein.sv
// Scoreboard bench for gcd_stein: directed cases, mid-run reset and a random
// sweep checked against a Euclid reference.
module tb_gcd_stein;

  localparam int W  = 16;
  localparam int IW = 10;
  localparam int CT = 4*W+2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  a_i = '0;
  logic [W-1:0]  b_i = '0;
  logic [W-1:0]  gcd;
  logic          finish;
  logic          busy;
  logic [IW-1:0] iters;

  gcd_stein #(.WIDTH(W), .ITER_W(IW), .CT_CYCLES(CT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a(a_i), .b(b_i), .gcd(gcd), .finish(finish),
    .busy(busy), .iters(iters)
  );

  always #5 clk = ~clk;

  typedef struct {
    int g;
    int it;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int passes = 0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int gcd_ref(int p, int q);
    int t;
    while (q != 0) begin
      t = p % q;
      p = q;
      q = t;
    end
    return p;
  endfunction

  // -1 means "exact count unknown, check the bound only"
  function automatic int exp_it(int nominal);
`ifdef GCD_STEIN_CONST_TIME_EN
    return CT;
`else
    return nominal;
`endif
  endfunction

  always @(posedge clk) begin
    #1;
    if (finish) begin
      if (sb.size() == 0) begin
        chk("unexpected_finish", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("gcd", int'(gcd), e.g);
        if (e.it >= 0) chk("iters", int'(iters), e.it);
        else chk("iters_bound",
                 int'(iters >= 1 && iters <= 4*W+1), 1);
      end
    end
  end

  task automatic run_op(int av, int bv, int it_nom, bit poke);
    int n;
    bit got;
    exp_t e;
    e.g  = gcd_ref(av, bv);
    e.it = exp_it(it_nom);
    @(negedge clk);
    a_i = W'(av);
    b_i = W'(bv);
    start = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
    n = 1;
    got = 1'b0;
    while (!got && n < 400) begin
      @(posedge clk);
      #1;
      n++;
      start = 1'b0;
      if (finish) got = 1'b1;
      else if (poke && n == 3) begin
        start = 1'b1;
        a_i = 7;
        b_i = 3;
      end
    end
    if (!got) chk("timeout", 0, 1);
    else if (e.it >= 0) chk("latency", n, e.it + 1);
    @(posedge clk);
    #1;
    chk("finish_pulse", int'(finish), 0);
    chk("busy_after", int'(busy), 0);
  endtask

  initial begin
    #12;
    chk("rst_gcd", int'(gcd), 0);
    chk("rst_finish", int'(finish), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_iters", int'(iters), 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(34, 12, 11, 1'b1);
    run_op(0, 0, 1, 1'b0);
    run_op(0, 5, 1, 1'b0);
    run_op(5, 0, 1, 1'b0);
    run_op(65535, 65535, 2, 1'b0);
    run_op(48, 18, -1, 1'b0);
    run_op(65535, 1, -1, 1'b0);

    // abandon an operation mid-CALC
    @(negedge clk);
    a_i = 34;
    b_i = 12;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_gcd", int'(gcd), 0);
    chk("midrst_finish", int'(finish), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_iters", int'(iters), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    run_op(35, 21, -1, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      int av;
      int bv;
      av = int'($urandom_range(0, 65535));
      bv = int'($urandom_range(0, 65535));
      if (i % 8 == 1) av = int'($urandom_range(0, 15));
      if (i % 8 == 2) bv = int'($urandom_range(0, 15));
      if (i % 16 == 3) av = av & 32'hFF00;
      run_op(av, bv, -1, 1'b0);
    end

    repeat (5) @(posedge clk);
    #1 chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
